// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and helpers for the instruction fetch queue.
// Optional zero-latency bypass is enabled with the IFQ_BYPASS_EN macro.
package inst_fetch_queue_pkg;

  localparam int IFQ_DEPTH = 4;
  localparam int IFQ_AW    = 32;
  localparam int IFQ_DW    = 32;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Occupancy update selected by {pop, push}
  typedef enum logic [1:0] {
    IFQ_HOLD = 2'b00,
    IFQ_PUSH = 2'b01,
    IFQ_POP  = 2'b10,
    IFQ_BOTH = 2'b11
  } ifq_op_e;

  function automatic ifq_op_e ifq_op(input logic push, input logic pop);
    return ifq_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// IF/ID-facing bundle of the instruction fetch queue.
// slave = the queue itself, master = the fetch/decode side driving it.
interface inst_fetch_queue_if
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = IFQ_AW,
  parameter int DW    = IFQ_DW
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          ce_i;
  logic [AW-1:0] pc_i;
  logic [DW-1:0] inst_i;
  logic          flush_i;
  logic          stall_o;
  logic          id_valid_o;
  logic          id_ready_i;
  logic [AW-1:0] id_pc_o;
  logic [DW-1:0] id_inst_o;
  logic [CW-1:0] count_o;

  modport slave (
    input  ce_i, pc_i, inst_i, flush_i, id_ready_i,
    output stall_o, id_valid_o, id_pc_o, id_inst_o, count_o
  );

  modport master (
    output ce_i, pc_i, inst_i, flush_i, id_ready_i,
    input  stall_o, id_valid_o, id_pc_o, id_inst_o, count_o
  );

endinterface

// File: rtl/inst_fetch_queue_mem.sv
// ifq_mem: DEPTH x W storage, one synchronous write port, one asynchronous read port.
// Data is never reset; validity is tracked by the pointers in the top.
module ifq_mem
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int W     = IFQ_AW + IFQ_DW
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction prefetch buffer between IF and ID: in-order {pc, inst} FIFO with flush on taken jump.
// IFQ_BYPASS_EN adds a combinational path from IF to ID while the queue is empty.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = IFQ_AW,
  parameter int DW    = IFQ_DW
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_queue_if.slave ifq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop_mem;
  logic             byp_take;
  logic             byp_vld;
  logic [AW+DW-1:0] head;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

`ifdef IFQ_BYPASS_EN
  assign byp_vld  = empty & ifq.ce_i & ~ifq.flush_i;
  assign byp_take = byp_vld & ifq.id_ready_i;
`else
  assign byp_vld  = 1'b0;
  assign byp_take = 1'b0;
`endif

  // A bypassed pair that ID takes directly never occupies a slot
  assign push    = ifq.ce_i & ~full & ~ifq.flush_i & ~byp_take;
  assign pop_mem = ~empty & ifq.id_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (ifq.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_mem) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case (ifq_op(push, pop_mem))
        IFQ_PUSH: count_d = count_q + CW'(1);
        IFQ_POP:  count_d = count_q - CW'(1);
        default:  count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  ifq_mem #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push & ~rst),
    .waddr_i (wr_ptr_q),
    .wdata_i ({ifq.pc_i, ifq.inst_i}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // stall_o comes from the registered count only, so id_ready_i never reaches IF combinationally
  always_comb begin
    ifq.stall_o    = full;
    ifq.count_o    = count_q;
    ifq.id_valid_o = ~empty;
    ifq.id_pc_o    = '0;
    ifq.id_inst_o  = DW'(NOP_INST);
    if (!empty) begin
      ifq.id_pc_o   = head[AW+DW-1:DW];
      ifq.id_inst_o = head[DW-1:0];
    end else if (byp_vld) begin
      ifq.id_valid_o = 1'b1;
      ifq.id_pc_o    = ifq.pc_i;
      ifq.id_inst_o  = ifq.inst_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH=4), with a small IF/ID model for mixed traffic.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [31:0] sb[$];
  logic [31:0] m_pc;
  logic [15:0] pat;

  inst_fetch_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) ifq ();

  inst_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .ifq (ifq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [31:0] p);
    return p ^ 32'hC0DE_0000;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ce, input logic [31:0] pc, input logic rdy, input logic fl);
    ifq.ce_i       = ce;
    ifq.pc_i       = pc;
    ifq.inst_i     = mk(pc);
    ifq.id_ready_i = rdy;
    ifq.flush_i    = fl;
  endtask

  // IF advances its pc only when the pair was taken; ID pops when ready and something is held
  task automatic model_step(input logic ce, input logic rdy, input string tag);
    logic do_push;
    logic do_pop;
    logic byp;
    int   sz;
    sz      = sb.size();
    drive(ce, m_pc, rdy, 1'b0);
    byp     = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp     = (sz == 0) && ce && rdy;
`endif
    do_pop  = (sz > 0) && rdy;
    do_push = ce && (sz < DEPTH) && !byp;
    cyc();
    if (do_pop) void'(sb.pop_front());
    if (do_push) sb.push_back(m_pc);
    if (do_push || byp) m_pc = m_pc + 32'd4;
    sz = sb.size();
    chk({tag, "_count"}, 64'(ifq.count_o), 64'(sz));
    chk({tag, "_stall"}, 64'(ifq.stall_o), 64'(sz == DEPTH));
    if (sz > 0) chk({tag, "_head"}, 64'(ifq.id_pc_o), 64'(sb[0]));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    // 1. reset
    cyc();
    cyc();
    chk("rst_count", 64'(ifq.count_o), 64'd0);
    chk("rst_valid", 64'(ifq.id_valid_o), 64'd0);
    chk("rst_stall", 64'(ifq.stall_o), 64'd0);
    chk("rst_inst", 64'(ifq.id_inst_o), 64'd0);
    chk("rst_pc", 64'(ifq.id_pc_o), 64'd0);
    rst = 1'b0;

    // 2. fill with ID stalled, hold, then drain in order
    drive(1'b1, 32'd0, 1'b0, 1'b0);
    cyc();
    chk("fill1_count", 64'(ifq.count_o), 64'd1);
    chk("fill1_head", 64'(ifq.id_pc_o), 64'd0);
    chk("fill1_inst", 64'(ifq.id_inst_o), 64'(mk(32'd0)));
    drive(1'b1, 32'd4, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'd8, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'd12, 1'b0, 1'b0);
    cyc();
    chk("full_count", 64'(ifq.count_o), 64'd4);
    chk("full_stall", 64'(ifq.stall_o), 64'd1);
    drive(1'b1, 32'd16, 1'b0, 1'b0);
    cyc();
    cyc();
    chk("hold_count", 64'(ifq.count_o), 64'd4);
    chk("hold_stall", 64'(ifq.stall_o), 64'd1);
    chk("hold_head", 64'(ifq.id_pc_o), 64'd0);
    drive(1'b1, 32'd16, 1'b1, 1'b0);
    #1;
    chk("drain_pc0", 64'(ifq.id_pc_o), 64'd0);
    cyc();
    chk("drain_count3", 64'(ifq.count_o), 64'd3);
    chk("drain_stall0", 64'(ifq.stall_o), 64'd0);
    chk("drain_pc4", 64'(ifq.id_pc_o), 64'd4);
    cyc();
    chk("drain_pushpop_count", 64'(ifq.count_o), 64'd3);
    chk("drain_pc8", 64'(ifq.id_pc_o), 64'd8);
    drive(1'b0, 32'd20, 1'b1, 1'b0);
    cyc();
    chk("drain_pc12", 64'(ifq.id_pc_o), 64'd12);
    cyc();
    chk("drain_pc16", 64'(ifq.id_pc_o), 64'd16);
    chk("drain_inst16", 64'(ifq.id_inst_o), 64'(mk(32'd16)));
    cyc();
    chk("drain_empty_count", 64'(ifq.count_o), 64'd0);
    chk("drain_empty_valid", 64'(ifq.id_valid_o), 64'd0);
    chk("drain_empty_inst", 64'(ifq.id_inst_o), 64'd0);

    // 3. flush with pop and wrong-path push in the same cycle
    drive(1'b1, 32'd0, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'd4, 1'b0, 1'b0);
    cyc();
    chk("preflush_count", 64'(ifq.count_o), 64'd2);
    drive(1'b1, 32'd8, 1'b1, 1'b1);
    cyc();
    chk("flush_count", 64'(ifq.count_o), 64'd0);
    chk("flush_valid", 64'(ifq.id_valid_o), 64'd0);
    drive(1'b1, 32'h40, 1'b0, 1'b0);
    cyc();
    chk("jaddr_count", 64'(ifq.count_o), 64'd1);
    chk("jaddr_head", 64'(ifq.id_pc_o), 64'h40);
    chk("jaddr_inst", 64'(ifq.id_inst_o), 64'(mk(32'h40)));
    drive(1'b0, 32'h44, 1'b1, 1'b0);
    cyc();
    chk("jaddr_drain", 64'(ifq.count_o), 64'd0);

    // flush while full releases the stall on the next cycle
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h80 + 32'(4 * i), 1'b0, 1'b0);
      cyc();
    end
    chk("full2_stall", 64'(ifq.stall_o), 64'd1);
    drive(1'b1, 32'h90, 1'b0, 1'b1);
    cyc();
    chk("flushfull_count", 64'(ifq.count_o), 64'd0);
    chk("flushfull_stall", 64'(ifq.stall_o), 64'd0);

    // reset mid-operation discards entries and ignores push/pop
    drive(1'b1, 32'hA0, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'hA4, 1'b0, 1'b0);
    cyc();
    rst = 1'b1;
    drive(1'b1, 32'hA8, 1'b1, 1'b0);
    cyc();
    chk("midrst_count", 64'(ifq.count_o), 64'd0);
    chk("midrst_valid", 64'(ifq.id_valid_o), 64'd0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    cyc();

    // 4. streaming through the pointer wrap
    drive(1'b1, 32'h200, 1'b0, 1'b0);
    cyc();
    for (int i = 1; i <= 3 * DEPTH; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0);
      cyc();
      chk($sformatf("stream%0d_count", i), 64'(ifq.count_o), 64'd1);
      chk($sformatf("stream%0d_pc", i), 64'(ifq.id_pc_o), 64'(32'h200 + 32'(4 * i)));
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cyc();
    chk("stream_drain", 64'(ifq.count_o), 64'd0);

    // 5. full queue with push+pop, then mixed traffic against the pc stream
    sb.delete();
    m_pc = 32'h300;
    for (int i = 0; i < DEPTH; i++) model_step(1'b1, 1'b0, "sb_fill");
    model_step(1'b1, 1'b1, "sb_fullpop");
    chk("sb_fullpop_3", 64'(ifq.count_o), 64'd3);
    model_step(1'b1, 1'b0, "sb_refill");
    chk("sb_refill_4", 64'(ifq.count_o), 64'd4);
    pat = 16'b1011_0010_1110_0101;
    for (int i = 0; i < 16; i++) model_step(1'b1, pat[i], $sformatf("sb_mix%0d", i));
    for (int i = 0; i < DEPTH + 1; i++) model_step(1'b0, 1'b1, "sb_drain");
    chk("sb_empty", 64'(ifq.id_valid_o), 64'd0);

    // 6. empty queue, IF presents a pair with ID ready
    drive(1'b1, 32'h100, 1'b1, 1'b0);
    #1;
`ifdef IFQ_BYPASS_EN
    chk("byp_valid", 64'(ifq.id_valid_o), 64'd1);
    chk("byp_pc", 64'(ifq.id_pc_o), 64'h100);
    cyc();
    chk("byp_count", 64'(ifq.count_o), 64'd0);
`else
    chk("nobyp_valid", 64'(ifq.id_valid_o), 64'd0);
    chk("nobyp_pc", 64'(ifq.id_pc_o), 64'd0);
    drive(1'b0, 32'h104, 1'b1, 1'b0);
    #1;
    chk("nobyp_valid_ce0", 64'(ifq.id_valid_o), 64'd0);
    drive(1'b1, 32'h100, 1'b1, 1'b0);
    cyc();
    chk("nobyp_count", 64'(ifq.count_o), 64'd1);
    chk("nobyp_valid_next", 64'(ifq.id_valid_o), 64'd1);
    chk("nobyp_pc_next", 64'(ifq.id_pc_o), 64'h100);
`endif
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cyc();
    chk("final_count", 64'(ifq.count_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
